// File: rtl/mul_pkg.sv
// Shared types and helpers for the shared-multiplier arbiter: tag format,
// default widths and the round-robin pick function.
package mul_pkg;

  localparam int MUL_SIZE_DEF = 56;
  localparam int RES_W_DEF    = 112;
  localparam int MUL_LAT_DEF  = 3;
  localparam int MAX_REQ      = 8;
  localparam int TAG_ID_W     = 3;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

  typedef struct packed {
    logic                found;
    logic [TAG_ID_W-1:0] idx;
  } rr_pick_t;

  // First set bit of req_vec at or after ptr, wrapping modulo num_req.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0]  req_vec,
                                       input logic [TAG_ID_W-1:0] ptr,
                                       input int                  num_req);
    rr_pick_t res;
    int       j;
    res.found = 1'b0;
    res.idx   = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= num_req) begin
        j = j - num_req;
      end else begin
        j = j;
      end
      if ((k < num_req) && !res.found) begin
        if (req_vec[j[TAG_ID_W-1:0]]) begin
          res.found = 1'b1;
          res.idx   = j[TAG_ID_W-1:0];
        end else begin
          res.found = 1'b0;
        end
      end else begin
        res.found = res.found;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mul_tag_pipe.sv
// Valid+ID shift register that travels alongside the multiplier pipeline so
// each product can be routed back to the requester that issued it.
module mul_tag_pipe
  import mul_pkg::*;
#(
  parameter int DEPTH = MUL_LAT_DEF
) (
  input  logic clk,
  input  logic clr,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t pipe_q [DEPTH];
  tag_t pipe_d [DEPTH];

  // Shift one stage per cycle; stage 0 takes the new tag.
  always_comb begin
    pipe_d[0] = tag_in;
    for (int i = 1; i < DEPTH; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Stage registers with synchronous clear that drops every tag in flight.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign tag_out = pipe_q[DEPTH-1];

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one pipelined multiplier among NUM_REQ requesters,
// with per-requester result slots held until the requester consumes them.
module mul_share_arbiter
  import mul_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int MUL_SIZE = MUL_SIZE_DEF,
  parameter int RES_W    = RES_W_DEF,
  parameter int MUL_LAT  = MUL_LAT_DEF,
  parameter int ID_W     = $clog2(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*MUL_SIZE-1:0] req_a,
  input  logic [NUM_REQ*MUL_SIZE-1:0] req_b,
  output logic [NUM_REQ-1:0]          resp_valid,
  input  logic [NUM_REQ-1:0]          resp_ready,
  output logic [NUM_REQ*RES_W-1:0]    resp_data,
  output logic                        mul_valid,
  output logic [MUL_SIZE-1:0]         mul_a,
  output logic [MUL_SIZE-1:0]         mul_b,
  input  logic [RES_W-1:0]            mul_res,
  output logic [ID_W:0]               inflight
);

  localparam int CNT_W = ID_W + 1;

  logic [ID_W-1:0]          ptr_q, ptr_d;
  logic [NUM_REQ-1:0]       busy_q, busy_d;
  logic [NUM_REQ-1:0]       resp_valid_q, resp_valid_d;
  logic [NUM_REQ*RES_W-1:0] resp_data_q, resp_data_d;
  logic                     mul_valid_q, mul_valid_d;
  logic [MUL_SIZE-1:0]      mul_a_q, mul_a_d;
  logic [MUL_SIZE-1:0]      mul_b_q, mul_b_d;
  tag_t                     issue_tag_q, issue_tag_d;
  logic [CNT_W-1:0]         inflight_q, inflight_d;

  logic [NUM_REQ-1:0] eligible_s;
  logic [NUM_REQ-1:0] grant_s;
  logic [NUM_REQ-1:0] release_s;
  rr_pick_t           pick_s;
  logic [ID_W-1:0]    win_id_s;
  logic               issue_s;
  tag_t               tail_tag_s;
  logic               cap_s;
  logic [ID_W-1:0]    cap_id_s;
  logic               unused_s;

  // Issue tag is registered alongside mul_valid so the tail lines up with mul_res.
  mul_tag_pipe #(
    .DEPTH (MUL_LAT)
  ) u_tag_pipe (
    .clk     (clk),
    .clr     (rst_n),
    .tag_in  (issue_tag_q),
    .tag_out (tail_tag_s)
  );

  // Round-robin grant over requesters that are asking and have nothing outstanding.
  always_comb begin
    eligible_s = req_valid & ~busy_q;
    pick_s     = rr_pick(MAX_REQ'(eligible_s), TAG_ID_W'(ptr_q), NUM_REQ);
    win_id_s   = pick_s.idx[ID_W-1:0];
    grant_s    = '0;
    if (pick_s.found && !rst_n) begin
      grant_s[win_id_s] = 1'b1;
    end else begin
      grant_s = '0;
    end
    issue_s   = |grant_s;
    release_s = resp_valid_q & resp_ready;
    cap_s     = tail_tag_s.valid;
    cap_id_s  = tail_tag_s.id[ID_W-1:0];
  end

  // Next state for issue, capture, release and the in-flight counter.
  always_comb begin
    ptr_d        = ptr_q;
    busy_d       = busy_q & ~release_s;
    resp_valid_d = resp_valid_q & ~release_s;
    resp_data_d  = resp_data_q;
    mul_valid_d  = 1'b0;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    issue_tag_d  = '0;
    inflight_d   = inflight_q;

    // A slot is only written while busy and not yet holding a result.
    if (cap_s) begin
      resp_valid_d[cap_id_s]                = 1'b1;
      resp_data_d[cap_id_s*RES_W +: RES_W] = mul_res;
    end else begin
      resp_valid_d = resp_valid_d;
    end

    if (issue_s) begin
      busy_d[win_id_s] = 1'b1;
      mul_valid_d      = 1'b1;
      mul_a_d          = req_a[win_id_s*MUL_SIZE +: MUL_SIZE];
      mul_b_d          = req_b[win_id_s*MUL_SIZE +: MUL_SIZE];
      issue_tag_d.valid = 1'b1;
      issue_tag_d.id    = TAG_ID_W'(win_id_s);
      if (win_id_s == ID_W'(NUM_REQ - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = win_id_s + ID_W'(1);
      end
    end else begin
      ptr_d = ptr_q;
    end

    case ({issue_s, cap_s})
      2'b10:   inflight_d = inflight_q + CNT_W'(1);
      2'b01:   inflight_d = inflight_q - CNT_W'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      ptr_q        <= '0;
      busy_q       <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      mul_valid_q  <= 1'b0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      issue_tag_q  <= '0;
      inflight_q   <= '0;
    end else begin
      ptr_q        <= ptr_d;
      busy_q       <= busy_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      mul_valid_q  <= mul_valid_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      issue_tag_q  <= issue_tag_d;
      inflight_q   <= inflight_d;
    end
  end

  assign req_ready  = grant_s;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign mul_valid  = mul_valid_q;
  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign inflight   = inflight_q;
  assign unused_s   = ^{tail_tag_s.id, pick_s.idx};

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed + randomized bench for mul_share_arbiter against a queue-based
// reference model with a stub fixed-latency multiplier.
module tb_mul_share_arbiter;

  localparam int N   = 4;
  localparam int MS  = 56;
  localparam int RW  = 112;
  localparam int LAT = 3;
  localparam int IW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*MS-1:0]   req_a;
  logic [N*MS-1:0]   req_b;
  logic [N-1:0]      resp_valid;
  logic [N-1:0]      resp_ready;
  logic [N*RW-1:0]   resp_data;
  logic              mul_valid;
  logic [MS-1:0]     mul_a;
  logic [MS-1:0]     mul_b;
  logic [RW-1:0]     mul_res;
  logic [IW:0]       inflight;

  mul_share_arbiter #(
    .NUM_REQ (N), .MUL_SIZE (MS), .RES_W (RW), .MUL_LAT (LAT)
  ) dut (
    .clk (clk), .rst_n (rst_n), .req_valid (req_valid), .req_ready (req_ready),
    .req_a (req_a), .req_b (req_b), .resp_valid (resp_valid), .resp_ready (resp_ready),
    .resp_data (resp_data), .mul_valid (mul_valid), .mul_a (mul_a), .mul_b (mul_b),
    .mul_res (mul_res), .inflight (inflight)
  );

  always #5 clk = ~clk;

  // Stub multiplier: product valid LAT cycles after mul_valid, junk otherwise.
  logic [RW-1:0] stub_p [LAT];
  logic          stub_v [LAT];
  initial begin
    for (int i = 0; i < LAT; i++) begin
      stub_p[i] = '0;
      stub_v[i] = 1'b0;
    end
  end
  always @(posedge clk) begin
    stub_p[0] <= {56'b0, mul_a} * {56'b0, mul_b};
    stub_v[0] <= mul_valid;
    for (int i = 1; i < LAT; i++) begin
      stub_p[i] <= stub_p[i-1];
      stub_v[i] <= stub_v[i-1];
    end
  end
  assign mul_res = stub_v[LAT-1] ? stub_p[LAT-1] : {56{2'b10}};

  // Reference model: outstanding ops as a queue of (id, product, capture cycle).
  typedef struct {
    int            id;
    logic [RW-1:0] prod;
    int            due;
  } pend_t;

  pend_t         pend[$];
  int            ptr_m;
  bit            busy_m [N];
  bit            rv_m [N];
  logic [RW-1:0] slot_m [N];
  bit            mv_m;
  logic [MS-1:0] ma_m, mb_m;
  int            cyc;
  int            checks = 0;
  int            passes = 0;

  function automatic logic [RW-1:0] prod(input logic [MS-1:0] a, input logic [MS-1:0] b);
    return {56'b0, a} * {56'b0, b};
  endfunction

  task automatic model_reset();
    ptr_m = 0;
    mv_m  = 1'b0;
    ma_m  = '0;
    mb_m  = '0;
    pend.delete();
    for (int i = 0; i < N; i++) begin
      busy_m[i] = 1'b0;
      rv_m[i]   = 1'b0;
      slot_m[i] = '0;
    end
  endtask

  task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
  endtask

  task automatic set_op(input int i, input logic [MS-1:0] a, input logic [MS-1:0] b);
    req_a[i*MS +: MS] = a;
    req_b[i*MS +: MS] = b;
  endtask

  // One clock cycle: check outputs mid-cycle, advance the model, step the clock.
  task automatic cycle();
    int           g;
    int           j;
    logic [N-1:0] exp_ready;
    @(negedge clk);
    g = -1;
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        j = (ptr_m + k) % N;
        if (g < 0 && req_valid[j] && !busy_m[j]) g = j;
      end
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    check("req_ready", RW'(req_ready), RW'(exp_ready));
    check("mul_valid", RW'(mul_valid), RW'(mv_m));
    check("mul_a", RW'(mul_a), RW'(ma_m));
    check("mul_b", RW'(mul_b), RW'(mb_m));
    check("inflight", RW'(inflight), RW'(pend.size()));
    for (int i = 0; i < N; i++) begin
      check($sformatf("resp_valid[%0d]", i), RW'(resp_valid[i]), RW'(rv_m[i]));
      check($sformatf("resp_data[%0d]", i), resp_data[i*RW +: RW], slot_m[i]);
    end
    if (rst_n) begin
      model_reset();
    end else begin
      for (int i = 0; i < N; i++) begin
        if (rv_m[i] && resp_ready[i]) begin
          rv_m[i]   = 1'b0;
          busy_m[i] = 1'b0;
        end
      end
      while (pend.size() > 0 && pend[0].due == cyc) begin
        slot_m[pend[0].id] = pend[0].prod;
        rv_m[pend[0].id]   = 1'b1;
        void'(pend.pop_front());
      end
      if (g >= 0) begin
        busy_m[g] = 1'b1;
        ma_m      = req_a[g*MS +: MS];
        mb_m      = req_b[g*MS +: MS];
        mv_m      = 1'b1;
        pend.push_back('{id: g, prod: prod(ma_m, mb_m), due: cyc + LAT + 1});
        ptr_m     = (g + 1) % N;
      end else begin
        mv_m = 1'b0;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  logic [63:0]   rnd_a, rnd_b;
  logic [MS-1:0] ones;
  logic [RW-1:0] ones_sq;

  initial begin
    cyc        = 0;
    rst_n      = 1'b1;
    req_valid  = '0;
    resp_ready = '0;
    req_a      = '0;
    req_b      = '0;
    ones       = {MS{1'b1}};
    ones_sq    = prod(ones, ones);
    model_reset();
    @(posedge clk);
    #1;
    run(2);
    rst_n = 1'b0;
    run(1);

    // Single op: 3*5 from requester 0, held until consumed.
    set_op(0, 56'd3, 56'd5);
    req_valid = 4'b0001;
    run(1);
    req_valid = 4'b0000;
    run(7);
    check("single_prod", resp_data[RW-1:0], 112'd15);
    resp_ready = 4'b0001;
    run(1);
    resp_ready = 4'b0000;
    run(1);

    // Round robin with distinct products per requester.
    for (int i = 0; i < N; i++) set_op(i, MS'(i + 1), 56'd1 << 54);
    req_valid  = 4'b1111;
    resp_ready = 4'b1111;
    run(24);

    // Backpressure on requester 2 while the others keep issuing.
    resp_ready = 4'b1011;
    for (int c = 0; c < 20; c++) begin
      for (int i = 0; i < N; i++) begin
        rnd_a = {$urandom(), $urandom()};
        rnd_b = {$urandom(), $urandom()};
        set_op(i, rnd_a[MS-1:0], rnd_b[MS-1:0]);
      end
      run(1);
    end
    resp_ready = 4'b1111;
    req_valid  = 4'b0000;
    run(8);

    // Reset with three ops in flight; late products must be ignored.
    resp_ready = 4'b0000;
    req_valid  = 4'b0111;
    run(3);
    req_valid = 4'b0000;
    run(1);
    rst_n = 1'b1;
    run(1);
    rst_n = 1'b0;
    run(6);
    set_op(3, 56'd7, 56'd9);
    req_valid = 4'b1000;
    run(1);
    req_valid = 4'b0000;
    run(6);
    check("post_reset_prod", resp_data[3*RW +: RW], 112'd63);
    resp_ready = 4'b1111;
    run(2);

    // Extreme operands keep all product bits.
    resp_ready = 4'b0000;
    set_op(0, ones, ones);
    req_valid = 4'b0001;
    run(1);
    req_valid = 4'b0000;
    run(6);
    check("extreme_prod", resp_data[RW-1:0], ones_sq);
    resp_ready = 4'b1111;
    run(2);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 400; c++) begin
      req_valid  = N'($urandom());
      resp_ready = N'($urandom());
      rst_n      = ($urandom_range(0, 79) == 0);
      for (int i = 0; i < N; i++) begin
        rnd_a = {$urandom(), $urandom()};
        rnd_b = {$urandom(), $urandom()};
        if ($urandom_range(0, 7) == 0) rnd_a = '1;
        set_op(i, rnd_a[MS-1:0], rnd_b[MS-1:0]);
      end
      run(1);
    end
    rst_n      = 1'b0;
    req_valid  = '0;
    resp_ready = '1;
    run(8);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Shares one fixed-latency pipelined 56x56 multiplier between NUM_REQ requesters, such as modular-reduction sequencers and operand loaders.
- Uses round-robin arbitration with a valid/ready request handshake and tracks requester IDs through the multiplier pipeline.
- Routes each product back to the requester that issued it and holds it there until that requester accepts it.
- Sits between the modmul control FSMs and the DSP-tiled multiplier instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- MUL_SIZE, 56, operand width
- RES_W, 112, product width returned by the multiplier
- MUL_LAT, 3, cycles from mul_valid/mul_a/mul_b to mul_res valid (>=1)
- ID_W, $clog2(NUM_REQ), requester tag width

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active-high (1 = reset), sampled on rising clk
- req_valid  in  NUM_REQ  per-requester operation request
- req_ready  out  NUM_REQ  per-requester accept (combinational)
- req_a  in  NUM_REQ*MUL_SIZE  operand a; requester i uses slice [i*MUL_SIZE +: MUL_SIZE]
- req_b  in  NUM_REQ*MUL_SIZE  operand b, same packing as req_a
- resp_valid  out  NUM_REQ  product held for requester i
- resp_ready  in  NUM_REQ  requester i consumes its product
- resp_data  out  NUM_REQ*RES_W  product slot per requester
- mul_valid  out  1  issue strobe to the multiplier (registered)
- mul_a  out  MUL_SIZE  multiplier operand a (registered)
- mul_b  out  MUL_SIZE  multiplier operand b (registered)
- mul_res  in  RES_W  multiplier product, valid exactly MUL_LAT cycles after its issue
- inflight  out  ID_W+1  count of issued operations not yet captured into a slot

Behaviour:
- Reset (rst_n=1 at an edge):
  - req_ready and resp_valid are 0.
  - mul_valid=0, mul_a=0, mul_b=0, resp_data=0, inflight=0.
  - Round-robin pointer is 0; busy[] and the tag pipeline are cleared.
- Reset mid-operation: all in-flight operations are dropped. Products arriving from the multiplier after reset are ignored because their tags are gone. No resp_valid follows.
- Eligibility: eligible[i] = req_valid[i] & ~busy[i]. busy is registered. Each requester has at most one operation outstanding.
- Arbitration: each cycle, grant the first eligible index at or after ptr, wrapping modulo NUM_REQ. req_ready is one-hot (or zero), i.e. req_ready[i] = grant[i].
- Pointer update: ptr <= winner+1 (mod NUM_REQ) on a grant; otherwise ptr holds.
- Accept at edge T (req_valid[w] & req_ready[w]):
  - busy[w] <= 1.
  - mul_a/mul_b <= req_a/req_b slices of w, and mul_valid <= 1 for exactly one cycle.
  - Tag {1,w} enters a MUL_LAT-deep shift register aligned with the multiplier.
- No grant in a cycle: mul_valid <= 0 and mul_a/mul_b hold their values.
- Capture: when the tag pipeline tail is valid with id w, resp_data slot w <= mul_res and resp_valid[w] <= 1.
- Latency: response is visible MUL_LAT+2 cycles after the accept edge. With MUL_LAT=3 this is 5 cycles. Throughput is 1 issue per cycle across requesters.
- Release: at an edge with resp_valid[i] & resp_ready[i]:
  - resp_valid[i] <= 0 and busy[i] <= 0.
  - Requester i becomes eligible in the following cycle, not the same cycle.
- Slot collision is impossible: a slot can only be written while its busy bit is set and its resp_valid is 0.
- resp_ready[i] while resp_valid[i]=0 is ignored.
- inflight: +1 on issue, -1 on capture; simultaneous issue and capture leaves it unchanged. Maximum value is NUM_REQ.
- Products are unmodified; bit slicing (e.g. upper-2 or middle radix bits) is the consumer's job.

Decomposition:
- Shared package mul_pkg holds:
  - MUL_SIZE, RES_W, MUL_LAT defaults;
  - a function rr_pick(req_vec, ptr) returning the winner index and a found flag;
  - the packed tag type {valid, id}.
- One natural sub-module, mul_tag_pipe: a parameterized MUL_LAT-deep valid+ID shift register with synchronous active-high clear. The arbiter, slot registers and counter stay in the top module.

Test Plan:
- Single op: req0 a=3, b=5 accepted at cycle 1 -> mul_valid pulses at cycle 2 with mul_a=3, mul_b=5. A stub multiplier returns 15 at cycle 5, resp_valid[0]=1 with resp_data[0]=15 from cycle 6. req_ready[0] stays 0 until resp_ready[0] is taken.
- Round robin: all 4 requesters valid continuously with resp_ready=1 -> grant order 0,1,2,3,0,... with one issue per cycle, each product routed to the correct slot. Use a=i+1, b=2^54 for requester i, checking product (i+1)<<54.
- Backpressure: requester 2 holds resp_ready=0 for 20 cycles -> it is never re-granted in that window, while requesters 0, 1 and 3 keep issuing. resp_data[2] stays stable.
- Accept/re-request boundary: resp_ready[1]=1 and req_valid[1]=1 in the same cycle -> the new op is granted the next cycle, never the same cycle. inflight never exceeds 4.
- Reset mid-flight: issue 3 ops, then assert rst_n for 1 cycle 1 cycle later -> all outputs return to 0 and late mul_res values produce no resp_valid. A new op from requester 3 then completes in MUL_LAT+2 cycles.
- Extremes: a=b=2^56-1 -> resp_data=(2^56-1)^2, full RES_W bits intact.
